mem_bus_arbiter: RTL

Two-requester arbiter that shares one single-port memory bus between the instruction-fetch path and the load/store path of the rv32 5-stage core. It serialises requests with one transaction outstanding, applies fixed MEM-over-IF priority with an optional anti-starvation guard, and issues per-requester stall signals so the pipeline freezes while its access is pending. It sits between the core's fetch and memory stages on one side and the shared instruction/data memory on the other. IF transactions are cancelled on a branch flush.

---
 rtl/mem_bus_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between fetch (IF) and load/store (MEM); one transaction outstanding.
// Define ARB_STARVE_GUARD_EN to bound how many times in a row IF can lose to MEM.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_be_i,
  output logic        mem_gnt_o,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_rdata_o,
  input  logic        fnb_flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        arb_if_stall_o,
  output logic        arb_mem_stall_o
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_e;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("STARVE_MAX must be in 1..15");
  end

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            discard_q, discard_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic [BW-1:0]   bus_be_q, bus_be_d;
  logic            force_if_c;

`ifdef ARB_STARVE_GUARD_EN
  logic [SW-1:0]   starve_q, starve_d;

  // Consecutive IDLE decisions that IF requested but lost to MEM.
  assign force_if_c = if_req_i && (starve_q == SW'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_IDLE) begin
      if (if_req_i && mem_req_i && !force_if_c) starve_d = starve_q + SW'(1);
      else                                     starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign force_if_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      discard_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      discard_q   <= discard_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    discard_d    = discard_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    if_gnt_o     = 1'b0;
    if_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    mem_gnt_o    = 1'b0;
    mem_rvalid_o = 1'b0;
    mem_rdata_o  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_req_i && !force_if_c) begin
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
          bus_be_d    = mem_be_i;
          owner_d     = OWN_MEM;
          state_d     = ST_REQ;
        end else if (if_req_i) begin
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
          bus_be_d    = '1;
          owner_d     = OWN_IF;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (owner_q == OWN_IF)  if_gnt_o  = bus_gnt_i;
        if (owner_q == OWN_MEM) mem_gnt_o = bus_gnt_i;
        // A flushed fetch already accepted by the bus must still drain its response.
        if (bus_gnt_i) begin
          state_d = ST_WAIT;
          if (owner_q == OWN_IF && fnb_flush_i) discard_d = 1'b1;
        end else if (owner_q == OWN_IF && fnb_flush_i) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      ST_WAIT: begin
        if (bus_rvalid_i) begin
          if (owner_q == OWN_MEM) begin
            mem_rvalid_o = 1'b1;
            mem_rdata_o  = bus_rdata_i;
          end else if (owner_q == OWN_IF && !discard_q && !fnb_flush_i) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = bus_rdata_i;
          end
          state_d   = ST_IDLE;
          owner_d   = OWN_NONE;
          discard_d = 1'b0;
        end else if (owner_q == OWN_IF && fnb_flush_i) begin
          discard_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  assign bus_req_d       = (state_d == ST_REQ);
  assign bus_req_o       = bus_req_q;
  assign bus_we_o        = bus_we_q;
  assign bus_addr_o      = bus_addr_q;
  assign bus_wdata_o     = bus_wdata_q;
  assign bus_be_o        = bus_be_q;
  assign arb_if_stall_o  = if_req_i && !if_rvalid_o && !fnb_flush_i;
  assign arb_mem_stall_o = mem_req_i && !mem_rvalid_o;

endmodule
